regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
// - Shares the single register-file write port (write_en/A3/WD3) between two writeback sources:
//   req0 = ALU writeback, req1 = load/debug unit.
// - Fixed priority to req0, with an aging counter so req1 is never starved.
// - One registered issue stage sits between the arbiter and the register file.
// - Enforces the x0-is-zero rule at the source: x0 writes are acknowledged but never issued.
// PARAMETERS
// - DATA_W   32  write data width
// - ADDR_W   5   register index width (32 registers)
// - MAX_WAIT 3   cycles req1 may lose arbitration before it is forced to win (>=1)
// PORTS
// - clk         in   1       rising-edge clock
// - rst         in   1       asynchronous, active-high reset
// - hold        in   1       1 = grant nothing this cycle; the issue stage still retires
// - req0_valid  in   1       ALU write request
// - req0_addr   in   ADDR_W  destination register
// - req0_data   in   DATA_W  write data
// - req0_ready  out  1       accept; handshake = valid & ready in the same cycle
// - req1_valid  in   1       load/debug write request
// - req1_addr   in   ADDR_W  destination register
// - req1_data   in   DATA_W  write data
// - req1_ready  out  1       accept for req1
// - rf_write_en out  1       register-file write_en
// - rf_addr     out  ADDR_W  register-file A3
// - rf_wdata    out  DATA_W  register-file WD3
// - starve_cnt  out  $clog2(MAX_WAIT+1)  current req1 age (debug)
// BEHAVIOUR
// - Reset (async):
//   - rf_write_en=0, rf_addr=0, rf_wdata=0, starve_cnt=0.
//   - Any staged write is discarded, not retried.
// - Readies are combinational from valid, hold and starve_cnt. No ready depends on its own valid.
//   - hold=1: req0_ready=0, req1_ready=0.
//   - Else if starve_cnt==MAX_WAIT: req1_ready=1, req0_ready=!req1_valid.
//   - Else: req0_ready=1, req1_ready=!req0_valid.
// - Exactly one handshake per cycle at most. The winner is latched into the issue stage at the clock edge.
// - Latency is 1 cycle: a handshake in cycle N gives rf_write_en=1 in cycle N+1, with the latched addr/data.
// - The register file always accepts, so the issue stage never stalls. Throughput is 1 write/cycle.
// - No handshake in cycle N: rf_write_en=0 in N+1. rf_addr/rf_wdata hold their last values.
// - Winner addr==0: the handshake completes and rf_write_en=0 in N+1. rf_addr/rf_wdata still update.
// - starve_cnt update at each edge:
//   - req1 handshake -> 0.
//   - req1_valid & !req1 handshake & !hold -> +1, saturating at MAX_WAIT.
//   - hold=1 -> unchanged.
//   - !req1_valid -> 0.
// - Same-address writes from both sources: they are serialized in grant order, so the later grant wins in the register file.
// - Requesters must hold valid/addr/data stable until the handshake. The block does not check this.
// STRUCTURE
// - Shared package: ADDR_W, DATA_W, REG_ZERO=0.
// - Shared package: typedef rf_wr_t {we, addr, data}, used by the issue stage and by both request sources.
// - One sub-module: rr_age_counter, the saturating starve counter that outputs force_req1.
// - Arbitration logic and the issue-stage register stay inline.
// TESTING
// - Reset with req0 valid (addr=5, data=0xAAAA0005) -> rf_write_en=0 until the first edge after rst falls; write issues the next cycle.
// - req0 (r3, 0x11) and req1 (r4, 0x22) both held valid, MAX_WAIT=3:
//   - req0 wins 3 cycles, req1 wins the 4th.
//   - rf sequence: r3, r3, r3, r4.
//   - starve_cnt sequence: 1, 2, 3, 0.
// - req1 alone, addr=0, data=0xDEAD -> req1_ready=1; next cycle rf_write_en=0, rf_addr=0.
// - hold=1 for 2 cycles with both valid -> both readies 0, starve_cnt frozen. A write staged before hold still issues on the first hold cycle.
// - Assert rst mid-stream while the stage holds (r7, 0x77) -> rf_write_en drops immediately (async); r7 is never written.
// - Back-to-back req0 writes r1..r4 on consecutive cycles -> rf_write_en=1 on 4 consecutive cycles, r1..r4 in order, no bubbles.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Purpose : Shared types and constants for the register-file write arbiter.
//           Holds the default data/address widths, the x0 register index and
//           the write-record struct used by both request sources and by the
//           issue stage.
// Contents: DATA_W, ADDR_W, REG_ZERO, rf_wr_t.
package regfile_write_arbiter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  // x0 is hard-wired to zero in the register file.
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  // One register-file write: enable, destination index, data.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/rr_age_counter.sv
// Purpose : Saturating age counter for the low-priority (req1) source.
//           Counts how many cycles req1 has been valid without winning;
//           when the count reaches MAX_WAIT it raises o_force_req so the
//           arbiter hands the write port to req1.
// Ports   : clk, rst        - clock, async active-high reset
//           i_hold          - freeze the count this cycle
//           i_req_valid     - req1 is requesting
//           i_req_hs        - req1 handshake completes this cycle
//           o_cnt           - current age
//           o_force_req     - age has reached MAX_WAIT
module rr_age_counter #(
  parameter int unsigned MAX_WAIT = 3,
  parameter int unsigned CNT_W    = $clog2(MAX_WAIT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_hold,
  input  logic             i_req_valid,
  input  logic             i_req_hs,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_force_req
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;

  // A win clears the age first; hold freezes it even if valid dropped.
  always_comb begin
    w_cnt_d = r_cnt;
    if (i_req_hs) begin
      w_cnt_d = '0;
    end else if (i_hold) begin
      w_cnt_d = r_cnt;
    end else if (!i_req_valid) begin
      w_cnt_d = '0;
    end else if (r_cnt != CntMax) begin
      w_cnt_d = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

  assign o_cnt       = r_cnt;
  assign o_force_req = (r_cnt == CntMax);

endmodule

// File: rtl/regfile_write_arbiter.sv
// Purpose : Shares the single register-file write port between the ALU
//           writeback (req0, fixed priority) and the load/debug unit (req1,
//           protected from starvation by an age counter). The winner is
//           latched into a one-deep issue stage that drives the register file
//           on the following cycle. Writes to x0 are acknowledged but never
//           issued.
// Ports   : clk, rst                         - clock, async active-high reset
//           hold                             - grant nothing this cycle
//           req0_valid/addr/data, req0_ready - ALU write request
//           req1_valid/addr/data, req1_ready - load/debug write request
//           rf_write_en, rf_addr, rf_wdata   - register-file write port
//           starve_cnt                       - current req1 age (debug)
// DATA_W/ADDR_W must match the package widths, since rf_wr_t is built on them.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W   = regfile_write_arbiter_pkg::DATA_W,
  parameter int unsigned ADDR_W   = regfile_write_arbiter_pkg::ADDR_W,
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            hold,
  input  logic                            req0_valid,
  input  logic [ADDR_W-1:0]               req0_addr,
  input  logic [DATA_W-1:0]               req0_data,
  output logic                            req0_ready,
  input  logic                            req1_valid,
  input  logic [ADDR_W-1:0]               req1_addr,
  input  logic [DATA_W-1:0]               req1_data,
  output logic                            req1_ready,
  output logic                            rf_write_en,
  output logic [ADDR_W-1:0]               rf_addr,
  output logic [DATA_W-1:0]               rf_wdata,
  output logic [$clog2(MAX_WAIT+1)-1:0]   starve_cnt
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  logic       w_force_req1;
  logic       w_req0_ready;
  logic       w_req1_ready;
  rf_wr_t     w_req0;
  rf_wr_t     w_req1;
  rf_wr_t     w_win;
  rf_wr_t     w_issue_d;
  rf_wr_t     r_issue;

  // Starve counter for req1.
  rr_age_counter #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_age (
    .clk         (clk),
    .rst         (rst),
    .i_hold      (hold),
    .i_req_valid (req1_valid),
    .i_req_hs    (w_req1.we),
    .o_cnt       (starve_cnt),
    .o_force_req (w_force_req1)
  );

  // Readies never look at their own valid, only at the other source's,
  // so at most one handshake can complete per cycle.
  always_comb begin
    w_req0_ready = 1'b0;
    w_req1_ready = 1'b0;
    if (hold) begin
      w_req0_ready = 1'b0;
      w_req1_ready = 1'b0;
    end else if (w_force_req1) begin
      w_req1_ready = 1'b1;
      w_req0_ready = !req1_valid;
    end else begin
      w_req0_ready = 1'b1;
      w_req1_ready = !req0_valid;
    end
  end

  assign req0_ready = w_req0_ready;
  assign req1_ready = w_req1_ready;

  // Request records: .we marks a completed handshake for that source.
  always_comb begin
    w_req0.we   = req0_valid & w_req0_ready;
    w_req0.addr = req0_addr;
    w_req0.data = req0_data;
    w_req1.we   = req1_valid & w_req1_ready;
    w_req1.addr = req1_addr;
    w_req1.data = req1_data;
  end

  // Handshakes are mutually exclusive, so a simple select picks the winner.
  assign w_win = w_req1.we ? w_req1 : w_req0;

  // No handshake: drop the enable but keep addr/data. x0 winner: update
  // addr/data, suppress the enable.
  always_comb begin
    w_issue_d    = r_issue;
    w_issue_d.we = 1'b0;
    if (w_win.we) begin
      w_issue_d.we   = (w_win.addr != REG_ZERO);
      w_issue_d.addr = w_win.addr;
      w_issue_d.data = w_win.data;
    end
  end

  // Reset discards any staged write; it is not retried.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_issue <= '0;
    end else begin
      r_issue <= w_issue_d;
    end
  end

  assign rf_write_en = r_issue.we;
  assign rf_addr     = r_issue.addr;
  assign rf_wdata    = r_issue.data;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst;
  logic        hold;
  logic        req0_valid;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        rf_write_en;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;
  logic [1:0]  starve_cnt;

  int n_cmp;
  int n_err;

  regfile_write_arbiter #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .MAX_WAIT (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .hold        (hold),
    .req0_valid  (req0_valid),
    .req0_addr   (req0_addr),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_addr   (req1_addr),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .rf_write_en (rf_write_en),
    .rf_addr     (rf_addr),
    .rf_wdata    (rf_wdata),
    .starve_cnt  (starve_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int exp_addr[4];
    int exp_data[4];
    int exp_cnt[4];
    n_cmp = 0;
    n_err = 0;

    // Reset with req0 already valid.
    rst        = 1'b1;
    hold       = 1'b0;
    req0_valid = 1'b1;
    req0_addr  = 5'd5;
    req0_data  = 32'hAAAA0005;
    req1_valid = 1'b0;
    req1_addr  = 5'd0;
    req1_data  = 32'h0;
    @(negedge clk);
    chk("rst_we", 32'(rf_write_en), 0);
    chk("rst_addr", 32'(rf_addr), 0);
    chk("rst_data", rf_wdata, 0);
    chk("rst_cnt", 32'(starve_cnt), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_we", 32'(rf_write_en), 0);
    chk("post_rst_r0rdy", 32'(req0_ready), 1);
    @(negedge clk);
    chk("first_we", 32'(rf_write_en), 1);
    chk("first_addr", 32'(rf_addr), 5);
    chk("first_data", rf_wdata, 32'hAAAA0005);
    req0_valid = 1'b0;
    @(negedge clk);
    chk("idle_we", 32'(rf_write_en), 0);
    chk("idle_addr_hold", 32'(rf_addr), 5);
    chk("idle_data_hold", rf_wdata, 32'hAAAA0005);

    // Contention: req0 wins three times, then req1 is forced through.
    req0_valid = 1'b1;
    req0_addr  = 5'd3;
    req0_data  = 32'h11;
    req1_valid = 1'b1;
    req1_addr  = 5'd4;
    req1_data  = 32'h22;
    exp_addr   = '{3, 3, 3, 4};
    exp_data   = '{32'h11, 32'h11, 32'h11, 32'h22};
    exp_cnt    = '{1, 2, 3, 0};
    #1;
    chk("cont_r0rdy0", 32'(req0_ready), 1);
    chk("cont_r1rdy0", 32'(req1_ready), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("cont_we", 32'(rf_write_en), 1);
      chk("cont_addr", 32'(rf_addr), 32'(exp_addr[i]));
      chk("cont_data", rf_wdata, 32'(exp_data[i]));
      chk("cont_cnt", 32'(starve_cnt), 32'(exp_cnt[i]));
      if (i == 2) begin
        chk("force_r1rdy", 32'(req1_ready), 1);
        chk("force_r0rdy", 32'(req0_ready), 0);
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    chk("cont_end_we", 32'(rf_write_en), 0);

    // req1 alone to x0: acknowledged, never written.
    req1_valid = 1'b1;
    req1_addr  = 5'd0;
    req1_data  = 32'hDEAD;
    #1;
    chk("x0_r1rdy", 32'(req1_ready), 1);
    @(negedge clk);
    chk("x0_we", 32'(rf_write_en), 0);
    chk("x0_addr", 32'(rf_addr), 0);
    chk("x0_data", rf_wdata, 32'hDEAD);
    chk("x0_cnt", 32'(starve_cnt), 0);
    req1_valid = 1'b0;

    // Stage a write, then hold for two cycles with both sources valid.
    req0_valid = 1'b1;
    req0_addr  = 5'd2;
    req0_data  = 32'h55;
    req1_valid = 1'b1;
    req1_addr  = 5'd6;
    req1_data  = 32'h66;
    @(negedge clk);
    hold = 1'b1;
    #1;
    chk("hold_we_staged", 32'(rf_write_en), 1);
    chk("hold_addr_staged", 32'(rf_addr), 2);
    chk("hold_r0rdy", 32'(req0_ready), 0);
    chk("hold_r1rdy", 32'(req1_ready), 0);
    chk("hold_cnt0", 32'(starve_cnt), 1);
    @(negedge clk);
    chk("hold1_we", 32'(rf_write_en), 0);
    chk("hold1_cnt", 32'(starve_cnt), 1);
    chk("hold1_r0rdy", 32'(req0_ready), 0);
    @(negedge clk);
    chk("hold2_we", 32'(rf_write_en), 0);
    chk("hold2_cnt", 32'(starve_cnt), 1);
    hold       = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    chk("unhold_cnt", 32'(starve_cnt), 0);
    chk("unhold_we", 32'(rf_write_en), 0);

    // Async reset while r7 is staged.
    req0_valid = 1'b1;
    req0_addr  = 5'd7;
    req0_data  = 32'h77;
    @(negedge clk);
    chk("r7_staged_we", 32'(rf_write_en), 1);
    chk("r7_staged_addr", 32'(rf_addr), 7);
    req0_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_we", 32'(rf_write_en), 0);
    chk("async_rst_addr", 32'(rf_addr), 0);
    chk("async_rst_data", rf_wdata, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("r7_never_we", 32'(rf_write_en), 0);

    // Back-to-back req0 writes r1..r4.
    for (int k = 1; k <= 4; k++) begin
      req0_valid = 1'b1;
      req0_addr  = 5'(k);
      req0_data  = 32'h100 + 32'(k);
      @(negedge clk);
      chk("b2b_we", 32'(rf_write_en), 1);
      chk("b2b_addr", 32'(rf_addr), 32'(k));
      chk("b2b_data", rf_wdata, 32'h100 + 32'(k));
    end
    req0_valid = 1'b0;
    @(negedge clk);
    chk("b2b_end_we", 32'(rf_write_en), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
